// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - shared constants for the multi-cycle MIPS control unit
// State encoding, opcodes, ALU codes and datapath select codes.
package multicycle_control_fsm_pkg;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_R_EXEC    = 4'd3;
  localparam logic [3:0] S_R_WB      = 4'd4;
  localparam logic [3:0] S_I_EXEC    = 4'd5;
  localparam logic [3:0] S_I_WB      = 4'd6;
  localparam logic [3:0] S_MEM_ADDR  = 4'd7;
  localparam logic [3:0] S_MEM_READ  = 4'd8;
  localparam logic [3:0] S_MEM_WRITE = 4'd9;
  localparam logic [3:0] S_MEM_WB    = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JUMP      = 4'd12;
  localparam logic [3:0] S_TRAP      = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

  function automatic logic is_wait_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// rtl/multicycle_control_fsm_mem_wait_timer.sv - memory wait counter with limit detect
// Counts consecutive not-ready cycles of one memory request.
module mem_wait_timer #(
  parameter int TIMEOUT_W = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic limit_o
);

  // limit_o flags the cycle that would be the (2**TIMEOUT_W-1)-th wait
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_o = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle MIPS control unit top
// Owns IR and the FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout trap.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4,
  parameter int TIMEOUT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready,
  input  logic                  zero,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  i_or_d,
  output logic                  ir_write,
  output logic                  pc_en,
  output logic [1:0]            pc_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [REG_ADDR_W-1:0] read_sel_a,
  output logic [REG_ADDR_W-1:0] read_sel_b,
  output logic [REG_ADDR_W-1:0] write_sel,
  output logic                  reg_write,
  output logic                  mem_to_reg,
  output logic                  illegal_op,
  output logic                  mem_timeout
);

  logic [3:0]        state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              timeout_q, timeout_d;
  logic              wait_limit;
  logic              pc_write, pc_write_cond;
  logic              active;
  logic [5:0]        opcode;
  logic              unused_ir_bits;

  assign opcode         = ir_q[DATA_W-1 -: 6];
  assign unused_ir_bits = ^ir_q[10:4];

  mem_wait_timer #(.TIMEOUT_W(TIMEOUT_W)) u_wait (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .clr_i   (state_d != state_q),
    .inc_i   (is_wait_state(state_q) && !mem_ready),
    .limit_o (wait_limit)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
          ir_d    = mem_rdata;
        end else if (wait_limit) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_ADDI:       state_d = S_I_EXEC;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_FETCH;
        endcase
      end
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (wait_limit) begin
          state_d = S_TRAP;
        end
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (wait_limit) begin
          state_d = S_TRAP;
        end
      end
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_TRAP) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_ctrl      = '0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        alu_ctrl  = ALU_CTRL_W'(ALU_ADD);
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRC_B_IMM_SH2;
        alu_ctrl   = ALU_CTRL_W'(ALU_ADD);
        illegal_op = !is_legal_op(opcode);
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_REG;
        alu_ctrl  = ALU_CTRL_W'(ir_q[3:0]);
      end
      S_I_EXEC, S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_ctrl  = ALU_CTRL_W'(ALU_ADD);
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = 1'b1;
      end
      S_R_WB, S_I_WB: reg_write = 1'b1;
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ctrl      = ALU_CTRL_W'(ALU_SUB);
        pc_write_cond = 1'b1;
        pc_src        = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
      end
      default: ;
    endcase
  end

  // Register selects are forced low outside active states so IDLE/TRAP drive all zeros
  assign active      = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign pc_en       = pc_write | (pc_write_cond & zero);
  assign mem_timeout = timeout_q;
  assign read_sel_a  = active ? REG_ADDR_W'(ir_q[25:21]) : '0;
  assign read_sel_b  = active ? REG_ADDR_W'(ir_q[20:16]) : '0;
  assign write_sel   = !active ? '0 :
                       (opcode == OP_RTYPE) ? REG_ADDR_W'(ir_q[15:11]) : REG_ADDR_W'(ir_q[20:16]);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm
// Phase-sequence model per instruction, per-cycle compare, plus literal pins.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       mem_req, mem_we, i_or_d, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic [4:0] read_sel_a, read_sel_b, write_sel;
    logic       reg_write, mem_to_reg, illegal_op, mem_timeout;
  } out_t;

  typedef enum {P_IDLE, P_FETCH, P_DECODE, P_REXEC, P_RWB, P_IEXEC, P_IWB,
                P_ADDR, P_RD, P_WR, P_MWB, P_BR, P_J, P_TRAP} phase_t;

  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;
  localparam int          LIMIT = 15;

  logic        clk = 1'b0;
  logic        rst_n, mem_ready, zero;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_en, alu_src_a;
  logic        reg_write, mem_to_reg, illegal_op, mem_timeout;
  logic [1:0]  pc_src, alu_src_b;
  logic [3:0]  alu_ctrl;
  logic [4:0]  read_sel_a, read_sel_b, write_sel;
  out_t        obs;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write), .pc_en(pc_en),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .read_sel_a(read_sel_a), .read_sel_b(read_sel_b), .write_sel(write_sel),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout)
  );

  assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                alu_ctrl, read_sel_a, read_sel_b, write_sel, reg_write, mem_to_reg,
                illegal_op, mem_timeout};

  // Stimulus-side state (written only by the initial block)
  out_t        exp_o, care_o;
  phase_t      exp_ph;
  logic        exp_valid;
  logic [31:0] ir_cur;
  logic        tmo;
  int          lit_req;
  string       lit_name [64];
  logic [63:0] lit_act [64];
  logic [63:0] lit_exp [64];
  int          s_rw, s_req, s_we, s_pc, s_ill;

  // Compare-side state (written only by the compare process)
  int          vectors = 0, miscompares = 0, lit_done = 0;
  int          rw_cnt = 0, req_cnt = 0, we_cnt = 0, pcen_cnt = 0, ill_cnt = 0;
  logic [4:0]  last_ws = '0;
  logic        last_m2r = 1'b0;

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic void model(input phase_t ph, input logic [31:0] ir, input logic rdy,
                                input logic z, input logic t, output out_t e, output out_t c);
    e = '0;
    c = '0;
    if (ph == P_IDLE || ph == P_TRAP) begin
      c = '1;
      e.mem_timeout = (ph == P_TRAP);
      return;
    end
    c.mem_req = 1; c.mem_we = 1; c.ir_write = 1; c.pc_en = 1; c.reg_write = 1;
    c.illegal_op = 1; c.mem_timeout = 1;
    c.read_sel_a = '1; c.read_sel_b = '1; c.write_sel = '1;
    e.mem_timeout = t;
    e.read_sel_a  = ir[25:21];
    e.read_sel_b  = ir[20:16];
    e.write_sel   = (ir[31:26] == 6'b000000) ? ir[15:11] : ir[20:16];
    case (ph)
      P_FETCH: begin
        c.i_or_d = 1; c.alu_src_a = 1; c.alu_src_b = '1; c.alu_ctrl = '1; c.pc_src = '1;
        e.mem_req = 1; e.alu_src_b = 2'b01; e.alu_ctrl = 4'b0010;
        e.ir_write = rdy; e.pc_en = rdy;
      end
      P_DECODE: begin
        c.alu_src_a = 1; c.alu_src_b = '1; c.alu_ctrl = '1;
        e.alu_src_b = 2'b11; e.alu_ctrl = 4'b0010; e.illegal_op = !legal(ir[31:26]);
      end
      P_REXEC: begin
        c.alu_src_a = 1; c.alu_src_b = '1; c.alu_ctrl = '1;
        e.alu_src_a = 1; e.alu_src_b = 2'b00; e.alu_ctrl = ir[3:0];
      end
      P_IEXEC: begin
        c.alu_src_a = 1; c.alu_src_b = '1; c.alu_ctrl = '1;
        e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_ctrl = 4'b0010;
      end
      P_ADDR: begin c.alu_ctrl = '1; e.alu_ctrl = 4'b0010; end
      P_RD: begin c.i_or_d = 1; e.mem_req = 1; e.i_or_d = 1; end
      P_WR: begin c.i_or_d = 1; e.mem_req = 1; e.i_or_d = 1; e.mem_we = 1; end
      P_RWB, P_IWB: begin c.mem_to_reg = 1; e.reg_write = 1; end
      P_MWB: begin c.mem_to_reg = 1; e.reg_write = 1; e.mem_to_reg = 1; end
      P_BR: begin
        c.alu_ctrl = '1; c.pc_src = '1;
        e.alu_ctrl = 4'b0110; e.pc_en = z; e.pc_src = 2'b01;
      end
      P_J: begin c.pc_src = '1; e.pc_en = 1; e.pc_src = 2'b10; end
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      vectors++;
      if (((obs ^ exp_o) & care_o) != '0) begin
        miscompares++;
        $display("FAIL cycle %s: got %h required %h (care %h)", exp_ph.name(), obs, exp_o, care_o);
      end
      if (obs.reg_write) begin
        rw_cnt++;
        last_ws  = obs.write_sel;
        last_m2r = obs.mem_to_reg;
      end
      if (obs.mem_req)    req_cnt++;
      if (obs.mem_we)     we_cnt++;
      if (obs.pc_en)      pcen_cnt++;
      if (obs.illegal_op) ill_cnt++;
    end
    while (lit_done < lit_req) begin
      vectors++;
      if (lit_act[lit_done] !== lit_exp[lit_done]) begin
        miscompares++;
        $display("FAIL %s: got %0h required %0h", lit_name[lit_done], lit_act[lit_done], lit_exp[lit_done]);
      end
      lit_done++;
    end
  end

  task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] expv);
    lit_name[lit_req] = nm;
    lit_act[lit_req]  = act;
    lit_exp[lit_req]  = expv;
    lit_req++;
  endtask

  task automatic step(input phase_t ph, input logic rdy, input logic [31:0] rdata, input logic z);
    mem_ready = rdy;
    mem_rdata = rdata;
    zero      = z;
    model(ph, ir_cur, rdy, z, tmo, exp_o, care_o);
    exp_ph    = ph;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // waits not-ready cycles then one ready cycle; a run of LIMIT not-ready cycles traps
  task automatic wait_phase(input phase_t ph, input int waits, input logic [31:0] rdata,
                            input logic z, inout int cyc, output bit trapped);
    trapped = 0;
    for (int i = 0; ; i++) begin
      if (i == LIMIT) begin
        trapped = 1;
        break;
      end
      step(ph, i == waits, (i == waits) ? rdata : JUNK, z);
      cyc++;
      if (i == waits) break;
    end
  endtask

  task automatic run(input logic [31:0] ir, input int fwait, input int mwait, input logic z,
                     output int cyc, output bit trapped);
    cyc = 0;
    wait_phase(P_FETCH, fwait, ir, z, cyc, trapped);
    if (trapped) return;
    ir_cur = ir;
    step(P_DECODE, 0, JUNK, z); cyc++;
    case (ir[31:26])
      6'b000000: begin step(P_REXEC, 0, JUNK, z); step(P_RWB, 0, JUNK, z); cyc += 2; end
      6'b001000: begin step(P_IEXEC, 0, JUNK, z); step(P_IWB, 0, JUNK, z); cyc += 2; end
      6'b100011: begin
        step(P_ADDR, 0, JUNK, z); cyc++;
        wait_phase(P_RD, mwait, JUNK, z, cyc, trapped);
        step(P_MWB, 0, JUNK, z); cyc++;
      end
      6'b101011: begin
        step(P_ADDR, 0, JUNK, z); cyc++;
        wait_phase(P_WR, mwait, JUNK, z, cyc, trapped);
      end
      6'b000100: begin step(P_BR, 0, JUNK, z); cyc++; end
      6'b000010: begin step(P_J, 0, JUNK, z); cyc++; end
      default: ;
    endcase
  endtask

  task automatic snap();
    s_rw = rw_cnt; s_req = req_cnt; s_we = we_cnt; s_pc = pcen_cnt; s_ill = ill_cnt;
  endtask

  initial begin
    int cyc;
    bit tr;
    rst_n = 1'b1; mem_ready = 1'b0; mem_rdata = '0; zero = 1'b0;
    exp_valid = 1'b0; ir_cur = '0; tmo = 1'b0; lit_req = 0;
    exp_o = '0; care_o = '0; exp_ph = P_IDLE;
    #2 rst_n = 1'b0;
    #1 lit("reset_outputs", 64'(obs), 64'd0);
    @(posedge clk); #1;
    step(P_IDLE, 1, JUNK, 0);
    step(P_IDLE, 1, JUNK, 0);
    rst_n = 1'b1;
    step(P_IDLE, 0, JUNK, 0);

    snap(); run(32'h2008_0005, 0, 0, 0, cyc, tr);
    lit("addi_cycles", 64'(cyc), 64'd4);
    lit("addi_reg_write_count", 64'(rw_cnt - s_rw), 64'd1);
    lit("addi_write_sel", 64'(last_ws), 64'd8);

    snap(); run(32'h0109_5025, 0, 0, 1, cyc, tr);
    lit("rtype_cycles", 64'(cyc), 64'd4);
    lit("rtype_write_sel", 64'(last_ws), 64'd10);

    snap(); run(32'h8C09_0004, 0, 3, 0, cyc, tr);
    lit("lw_cycles", 64'(cyc), 64'd8);
    lit("lw_mem_req_cycles", 64'(req_cnt - s_req), 64'd5);
    lit("lw_write_sel", 64'(last_ws), 64'd9);
    lit("lw_mem_to_reg", 64'(last_m2r), 64'd1);

    snap(); run(32'hAC0A_0008, 2, 0, 0, cyc, tr);
    lit("sw_cycles", 64'(cyc), 64'd6);
    lit("sw_mem_we_count", 64'(we_cnt - s_we), 64'd1);
    lit("sw_no_reg_write", 64'(rw_cnt - s_rw), 64'd0);

    snap(); run(32'h1000_0003, 0, 0, 1, cyc, tr);
    lit("beq_cycles", 64'(cyc), 64'd3);
    lit("beq_taken_pc_en", 64'(pcen_cnt - s_pc), 64'd2);
    snap(); run(32'h1000_0003, 0, 0, 0, cyc, tr);
    lit("beq_not_taken_pc_en", 64'(pcen_cnt - s_pc), 64'd1);

    snap(); run(32'h0800_0010, 0, 0, 0, cyc, tr);
    lit("j_cycles", 64'(cyc), 64'd3);

    snap(); run(32'hFC00_0000, 0, 0, 0, cyc, tr);
    lit("illegal_cycles", 64'(cyc), 64'd2);
    lit("illegal_pulse_count", 64'(ill_cnt - s_ill), 64'd1);
    lit("illegal_no_writes", 64'((rw_cnt - s_rw) + (we_cnt - s_we)), 64'd0);

    snap(); run(32'h0800_0010, 14, 0, 0, cyc, tr);
    lit("ready_at_limit_no_trap", 64'(tr), 64'd0);
    lit("ready_at_limit_cycles", 64'(cyc), 64'd17);

    step(P_FETCH, 1, 32'h8C09_0004, 0);
    ir_cur = 32'h8C09_0004;
    step(P_DECODE, 0, JUNK, 0);
    step(P_ADDR, 0, JUNK, 0);
    exp_valid = 1'b0;
    mem_ready = 1'b0;
    #1 lit("in_mem_read", 64'({mem_req, i_or_d}), 64'd3);
    #1 rst_n = 1'b0;
    #1 lit("reset_mid_read_outputs", 64'(obs), 64'd0);
    ir_cur = '0;
    @(posedge clk); #1;
    step(P_IDLE, 1, JUNK, 0);
    rst_n = 1'b1;
    step(P_IDLE, 0, JUNK, 0);

    snap(); run(32'h2008_0005, 0, 0, 0, cyc, tr);
    lit("addi_after_reset_cycles", 64'(cyc), 64'd4);

    snap(); run(32'h0800_0010, 100, 0, 0, cyc, tr);
    lit("trap_taken", 64'(tr), 64'd1);
    lit("trap_wait_cycles", 64'(cyc), 64'd15);
    tmo = 1'b1;
    repeat (3) step(P_TRAP, 0, JUNK, 0);
    repeat (2) step(P_TRAP, 1, 32'h0800_0010, 0);
    lit("trap_timeout_sticky", 64'(mem_timeout), 64'd1);

    rst_n = 1'b0;
    #1 lit("timeout_cleared_by_reset", 64'(mem_timeout), 64'd0);
    tmo = 1'b0;
    ir_cur = '0;
    step(P_IDLE, 0, JUNK, 0);
    exp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
